if_pc_redirect: RTL and testbench
=================================

// Module: if_pc_redirect
// PURPOSE
//  Fetch-side consumer of the MEM-stage branch decision. Owns the program counter,
//  applies sequential advance, holds, and branch redirects, and squashes wrong-path
//  instructions in IF/ID, ID/EX and EX/MEM when PC_Src is taken.
//  Sits between the MEM branch resolver, the hazard unit and the instruction memory.
// PARAMETERS
//  XLEN      32     PC / target width
//  RESET_PC  32'h0  PC value loaded on reset
//  PC_STEP   4      sequential increment in bytes
// PORTS
//  clk            in   1     single clock, all state updates on rising edge
//  rst_n          in   1     reset, synchronous, active-low
//  PC_Src         in   1     taken-branch decision from MEM stage
//  branch_target  in   XLEN  redirect address, valid when PC_Src=1
//  stall          in   1     hazard-unit hold request
//  imem_ready     in   1     instruction memory can accept/return this cycle
//  pc_out         out  XLEN  current fetch address (registered)
//  pc_plus4       out  XLEN  pc_out + PC_STEP, modulo 2^XLEN
//  fetch_valid    out  1     pc_out is a real fetch; IF/ID captures on fetch_valid&imem_ready&~stall
//  flush_if_id    out  1     squash IF/ID this cycle
//  flush_id_ex    out  1     squash ID/EX this cycle
//  flush_ex_mem   out  1     squash EX/MEM this cycle
//  misalign_err   out  1     sticky: taken target had target[1:0]!=0
// BEHAVIOUR
//  - Reset (rst_n=0 at rising edge, any state, mid-operation included): pc_out=RESET_PC,
//    state=BOOT, fetch_valid=0, misalign_err=0, flushes=0; takes effect only at the edge.
//  - FSM states: BOOT, RUN, HALT.
//    BOOT: one cycle after reset release; fetch_valid=0, PC_Src ignored, pc held; -> RUN.
//    RUN: fetch_valid=1. Priority per cycle: redirect > hold > advance.
//      redirect: PC_Src=1 and branch_target[1:0]==0 -> pc_out<=branch_target next edge,
//        regardless of stall/imem_ready (outstanding fetch abandoned). All three flush_*
//        are 1 combinationally in the same cycle as PC_Src. Latency: target on pc_out 1 cycle later.
//      misaligned: PC_Src=1 and branch_target[1:0]!=0 -> flushes=1 this cycle,
//        misalign_err<=1, pc held, -> HALT.
//      hold: stall=1 or imem_ready=0 -> pc_out unchanged.
//      advance: otherwise pc_out<=pc_plus4.
//    HALT: fetch_valid=0, flushes=0, pc held, all inputs ignored; exits only via reset.
//  - Flushes are 0 in BOOT and HALT and whenever PC_Src=0.
//  - Arithmetic unsigned, XLEN bits; 0xFFFFFFFC + 4 wraps to 0x00000000, no flag.
//  - PC_Src and stall both high: redirect wins, stall ignored for the PC that cycle.
//  - Back-to-back PC_Src cycles: each cycle redirects independently; last target wins.
// CONFIGURATION
//  PC_REDIRECT_STATS_EN defined: adds outputs redirect_cnt[31:0] (increments on each
//    accepted aligned redirect) and hold_cnt[31:0] (increments each RUN cycle in hold);
//    both reset to 0, wrap at 2^32, frozen in BOOT/HALT.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 rst_n=0 two cycles, then 1 -> pc_out=0x0, fetch_valid=0 one cycle (BOOT), then 1.
//  2 RUN, imem_ready=1, stall=0, 4 cycles -> pc_out 0x0,0x4,0x8,0xC; flushes stay 0.
//  3 pc_out=0x10, stall=1 3 cycles then imem_ready=0 2 cycles -> pc_out stays 0x10; resumes 0x14.
//  4 pc_out=0x20, PC_Src=1, target=0x100, stall=1 -> all flush_*=1 that cycle, pc_out=0x100
//    next; with PC_REDIRECT_STATS_EN redirect_cnt=1.
//  5 PC_Src=1, target=0x102 -> flushes=1 once, misalign_err=1 sticky, fetch_valid=0, pc held;
//    further PC_Src ignored; rst_n=0 clears to pc=0x0, BOOT.
//  6 Redirect to 0xFFFFFFFC, advance -> pc_out=0x0; rst_n=0 mid-stall -> pc_out=0x0 next edge.

Source files
------------

// File: rtl/if_pc_redirect.sv
// +----------------------------------------------------------------------------+
// | if_pc_redirect : fetch PC owner; sequential advance, hold, MEM redirect     |
// | and wrong-path squash. Optional PC_REDIRECT_STATS_EN adds event counters.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_pc_redirect #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PC_Src,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            flush_ex_mem,
  output logic            misalign_err
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     hold_cnt
`endif
);

  localparam logic [1:0] c_st_boot = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_halt = 2'd2;

  localparam logic [XLEN-1:0] c_reset_pc = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] c_pc_step  = XLEN'(PC_STEP);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_misalign;
  logic            w_run;
  logic            w_target_aligned;
  logic            w_redirect;
  logic            w_misalign;
  logic            w_hold;
  logic            w_flush;

  assign w_run            = (r_state == c_st_run);
  assign w_target_aligned = (branch_target[1:0] == 2'b00);
  assign w_redirect       = w_run & PC_Src & w_target_aligned;
  assign w_misalign       = w_run & PC_Src & ~w_target_aligned;
  assign w_hold           = w_run & ~PC_Src & (stall | ~imem_ready);

  // State register, together with the PC and the sticky error it controls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= c_st_boot;
      r_pc       <= c_reset_pc;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_misalign) begin
        r_misalign <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      c_st_boot: begin
        w_state_nxt = c_st_run;
      end
      c_st_run: begin
        // Redirect beats hold: an outstanding fetch is abandoned on a taken branch
        if (w_redirect) begin
          w_pc_nxt = branch_target;
        end else if (w_misalign) begin
          w_state_nxt = c_st_halt;
        end else if (!w_hold) begin
          w_pc_nxt = r_pc + c_pc_step;
        end
      end
      c_st_halt: begin
        w_state_nxt = c_st_halt;
      end
      default: begin
        w_state_nxt = c_st_halt;
      end
    endcase
  end

  always_comb begin
    fetch_valid = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      c_st_run: begin
        fetch_valid = 1'b1;
        w_flush     = PC_Src;
      end
      default: begin
        fetch_valid = 1'b0;
        w_flush     = 1'b0;
      end
    endcase
  end

  assign pc_out       = r_pc;
  assign pc_plus4     = r_pc + c_pc_step;
  assign flush_if_id  = w_flush;
  assign flush_id_ex  = w_flush;
  assign flush_ex_mem = w_flush;
  assign misalign_err = r_misalign;

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] r_redirect_cnt;
  logic [31:0] r_hold_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_redirect_cnt <= 32'd0;
      r_hold_cnt     <= 32'd0;
    end else begin
      if (w_redirect) begin
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
      end
      if (w_hold) begin
        r_hold_cnt <= r_hold_cnt + 32'd1;
      end
    end
  end

  assign redirect_cnt = r_redirect_cnt;
  assign hold_cnt     = r_hold_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_pc_redirect.sv
// Directed bench for if_pc_redirect: reset/boot, advance, hold, redirect,
// misaligned halt, wrap-around and reset during stall.
`default_nettype none

module tb_if_pc_redirect;

  logic        clk;
  logic        rst_n;
  logic        PC_Src;
  logic [31:0] branch_target;
  logic        stall;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic        misalign_err;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] redirect_cnt;
  logic [31:0] hold_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  if_pc_redirect #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PC_Src        (PC_Src),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .flush_ex_mem  (flush_ex_mem),
    .misalign_err  (misalign_err)
`ifdef PC_REDIRECT_STATS_EN
    ,
    .redirect_cnt  (redirect_cnt),
    .hold_cnt      (hold_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks pc and the flag outputs together; flush value applies to all three
  task automatic check_all(input string tag, input logic [31:0] pc, input logic fv,
                           input logic fl, input logic me);
    check({tag, ".pc"}, pc_out, pc);
    check({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, fv});
    check({tag, ".flush"}, {29'd0, flush_if_id, flush_id_ex, flush_ex_mem}, {29'd0, fl, fl, fl});
    check({tag, ".merr"}, {31'd0, misalign_err}, {31'd0, me});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; PC_Src = 1'b0; branch_target = 32'h0; stall = 1'b0; imem_ready = 1'b1;

    // Reset held two edges, then BOOT for one cycle
    tick(); tick();
    check_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 check_all("boot", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("run0", 32'h0, 1'b1, 1'b0, 1'b0);
    check("run0.plus4", pc_plus4, 32'h4);

    // Sequential advance
    tick(); check_all("adv4", 32'h4, 1'b1, 1'b0, 1'b0);
    tick(); check_all("adv8", 32'h8, 1'b1, 1'b0, 1'b0);
    tick(); check_all("advC", 32'hC, 1'b1, 1'b0, 1'b0);
    tick(); check("adv10", pc_out, 32'h10);

    // Holds: stall then memory not ready
    stall = 1'b1;
    tick(); tick(); tick();
    check("stall3", pc_out, 32'h10);
    stall = 1'b0; imem_ready = 1'b0;
    tick(); tick();
    check("notready2", pc_out, 32'h10);
    imem_ready = 1'b1;
    tick(); check("resume14", pc_out, 32'h14);
    tick(); tick(); tick();
    check("adv20", pc_out, 32'h20);

    // Redirect wins over stall; flush is combinational in the same cycle
    PC_Src = 1'b1; branch_target = 32'h100; stall = 1'b1;
    #1 check_all("redir.pre", 32'h20, 1'b1, 1'b1, 1'b0);
    tick();
    PC_Src = 1'b0; stall = 1'b0;
    #1 check_all("redir.post", 32'h100, 1'b1, 1'b0, 1'b0);
`ifdef PC_REDIRECT_STATS_EN
    check("redir.cnt", redirect_cnt, 32'd1);
    check("hold.cnt", hold_cnt, 32'd5);
`endif

    // Back-to-back redirects, each independent
    PC_Src = 1'b1; branch_target = 32'h200;
    tick(); check("b2b.1", pc_out, 32'h200);
    branch_target = 32'h300;
    tick(); check("b2b.2", pc_out, 32'h300);

    // Wrap-around at top of address space
    branch_target = 32'hFFFF_FFFC;
    tick();
    PC_Src = 1'b0;
    #1 check("wrap.pc", pc_out, 32'hFFFF_FFFC);
    check("wrap.plus4", pc_plus4, 32'h0);
    tick(); check_all("wrap.adv", 32'h0, 1'b1, 1'b0, 1'b0);

    // Misaligned target halts with sticky error
    PC_Src = 1'b1; branch_target = 32'h102;
    #1 check_all("mis.pre", 32'h0, 1'b1, 1'b1, 1'b0);
    tick(); check_all("mis.halt", 32'h0, 1'b0, 1'b0, 1'b1);
    branch_target = 32'h100;
    tick(); check_all("mis.ignored", 32'h0, 1'b0, 1'b0, 1'b1);
    PC_Src = 1'b0;
    tick(); check_all("mis.sticky", 32'h0, 1'b0, 1'b0, 1'b1);

    // Reset clears the halt
    rst_n = 1'b0;
    tick(); check_all("rst2", 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(); check_all("rst2.run", 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    check("rst2.adv8", pc_out, 32'h8);

    // Reset during stall takes effect only at the edge
    stall = 1'b1; rst_n = 1'b0;
    #1 check("midrst.pre", pc_out, 32'h8);
    tick(); check_all("midrst.post", 32'h0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
